// File: rtl/e203_wfi_pkg.sv
// rtl/e203_wfi_pkg.sv - shared state encoding and defaults for the WFI sleep controller
//
// Purpose : state encoding of the WFI sequencing FSM and default parameter values.
// Contents: wfi_state_e (WFI_RUN/WFI_DRAIN/WFI_SLEEP/WFI_WAKE), WAKE_DLY_DEFAULT, CNT_W_DEFAULT.
package e203_wfi_pkg;

  typedef enum logic [1:0] {
    WFI_RUN   = 2'b00,
    WFI_DRAIN = 2'b01,
    WFI_SLEEP = 2'b10,
    WFI_WAKE  = 2'b11
  } wfi_state_e;

  localparam int WAKE_DLY_DEFAULT = 2;
  localparam int CNT_W_DEFAULT    = 4;

endpackage

// File: rtl/e203_wfi_dly_cnt.sv
// rtl/e203_wfi_dly_cnt.sv - load/decrement/zero-detect counter for the post-wake settle delay
//
// Purpose : holds the number of remaining WAKE cycles before fetch may resume.
// Ports   : i_clk      - always-on clock
//           i_rst      - synchronous active-high reset, clears the count
//           i_load     - load i_load_val (has priority over decrement)
//           i_load_val - value loaded on i_load
//           i_dec      - decrement by one; held at zero once reached
//           o_zero     - count is zero
module e203_wfi_dly_cnt
  import e203_wfi_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/e203_wfi_ctrl.sv
// rtl/e203_wfi_ctrl.sv - WFI sleep entry/exit sequencer in front of the clock controller
//
// Purpose : halts IFU fetch on a committed WFI, waits for the pipeline to drain, raises
//           core_wfi (IFU clock gate), and on wake releases core_wfi then holds fetch for
//           WAKE_DLY+1 cycles before resuming with a one-cycle wfi_wake pulse.
// Optional: E203_WFI_SLEEP_CNT_EN adds i_sleep_cnt_clr / o_sleep_cycles (saturating
//           count of cycles spent in SLEEP).
// Ports   : i_clk, i_rst (sync, active-high)
//           i_wfi_req      - WFI commit pulse
//           i_dbg_mode     - debug mode, WFI becomes a NOP
//           i_wake_irq     - pending enabled interrupt (level)
//           i_dbg_irq      - debug halt request (level)
//           i_ifu_halt_ack - IFU has stopped fetching
//           i_pipe_idle    - no outstanding pipeline/bus work
//           o_ifu_halt_req - ask IFU to stop fetching
//           o_core_wfi     - gates the IFU clock
//           o_wfi_wake     - pulse when fetch resumes
//           o_wfi_state    - current FSM state
module e203_wfi_ctrl
  import e203_wfi_pkg::*;
#(
  parameter int WAKE_DLY = WAKE_DLY_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wfi_req,
  input  logic        i_dbg_mode,
  input  logic        i_wake_irq,
  input  logic        i_dbg_irq,
  input  logic        i_ifu_halt_ack,
  input  logic        i_pipe_idle,
`ifdef E203_WFI_SLEEP_CNT_EN
  input  logic        i_sleep_cnt_clr,
  output logic [31:0] o_sleep_cycles,
`endif
  output logic        o_ifu_halt_req,
  output logic        o_core_wfi,
  output logic        o_wfi_wake,
  output logic [1:0]  o_wfi_state
);

  localparam logic [CNT_W-1:0] LP_WAKE_DLY = CNT_W'(WAKE_DLY);

  wfi_state_e r_state;
  wfi_state_e w_nxt;
  logic       w_wake;
  logic       w_cnt_load;
  logic       w_cnt_dec;
  logic       w_cnt_zero;
  logic       r_ifu_halt_req;
  logic       r_core_wfi;
  logic       r_wfi_wake;

  assign w_wake = i_wake_irq | i_dbg_irq;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= WFI_RUN;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      WFI_RUN: begin
        if (i_wfi_req && !i_dbg_mode) w_nxt = WFI_DRAIN;
      end
      WFI_DRAIN: begin
        // A pending wake turns the WFI into a NOP before the clock is ever gated.
        if (w_wake)                             w_nxt = WFI_WAKE;
        else if (i_ifu_halt_ack && i_pipe_idle) w_nxt = WFI_SLEEP;
      end
      WFI_SLEEP: begin
        if (w_wake) w_nxt = WFI_WAKE;
      end
      WFI_WAKE: begin
        // Once started, the settle sequence runs to completion regardless of wake level.
        if (w_cnt_zero) w_nxt = WFI_RUN;
      end
      default: w_nxt = WFI_RUN;
    endcase
  end

  assign w_cnt_load = (w_nxt == WFI_WAKE) && (r_state != WFI_WAKE);
  assign w_cnt_dec  = (r_state == WFI_WAKE);

  e203_wfi_dly_cnt #(
    .CNT_W (CNT_W)
  ) u_dly_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (LP_WAKE_DLY),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Outputs come straight from flops computed off the next state, so the clock
  // controller never sees decode glitches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ifu_halt_req <= 1'b0;
      r_core_wfi     <= 1'b0;
      r_wfi_wake     <= 1'b0;
    end else begin
      r_ifu_halt_req <= (w_nxt != WFI_RUN);
      r_core_wfi     <= (w_nxt == WFI_SLEEP);
      r_wfi_wake     <= (r_state == WFI_WAKE) && (w_nxt == WFI_RUN);
    end
  end

  assign o_ifu_halt_req = r_ifu_halt_req;
  assign o_core_wfi     = r_core_wfi;
  assign o_wfi_wake     = r_wfi_wake;
  assign o_wfi_state    = r_state;

`ifdef E203_WFI_SLEEP_CNT_EN
  logic [31:0] r_sleep_cycles;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_sleep_cnt_clr) begin
      r_sleep_cycles <= '0;
    end else if ((r_state == WFI_SLEEP) && (r_sleep_cycles != 32'hFFFF_FFFF)) begin
      r_sleep_cycles <= r_sleep_cycles + 32'd1;
    end
  end

  assign o_sleep_cycles = r_sleep_cycles;
`endif

endmodule

// File: doc/e203_wfi_ctrl.md
Name: e203_wfi_ctrl

Overview:
- Sequences the core into and out of WFI sleep.
- Halts IFU fetch, waits for the pipeline to drain, then asserts core_wfi. core_wfi is the signal the clock-control stage uses to gate the IFU clock.
- On a wake event, releases core_wfi and holds fetch halted for a programmable settle delay before resuming.
- Sits directly upstream of the clock controller and runs on the always-on clock.

Parameters:
- WAKE_DLY, 2, cycles IFU halt is held in WAKE after core_wfi drops (0..15 legal).
- CNT_W, 4, width of wake-delay counter; must hold WAKE_DLY.

Ports:
- clk  input  1  always-on clock.
- rst  input  1  reset.
- wfi_req  input  1  one-cycle pulse when a WFI instruction commits.
- dbg_mode  input  1  core is in debug mode; WFI is a NOP.
- wake_irq  input  1  level: any enabled ext/sft/tmr interrupt pending.
- dbg_irq  input  1  level: debug halt request.
- ifu_halt_ack  input  1  IFU has stopped issuing fetches.
- pipe_idle  input  1  OITF empty and LSU/BIU have no outstanding transactions.
- ifu_halt_req  output  1  request IFU to stop fetching.
- core_wfi  output  1  to clock controller; gates IFU clock.
- wfi_wake  output  1  one-cycle pulse when fetch resumes after WFI.
- wfi_state  output  2  current FSM state, for debug/CSR visibility.

Behaviour:
- Reset: single clock clk; rst is synchronous, active-high.
  - Reset forces state RUN and wake counter 0.
  - Reset drives ifu_halt_req=0, core_wfi=0, wfi_wake=0, wfi_state=2'b00.
  - Reset asserted in any state returns to RUN on the next edge, with no wfi_wake pulse.
- All outputs are registered. Wake = wake_irq | dbg_irq.
- RUN (00):
  - wfi_req & ~dbg_mode -> DRAIN.
  - wfi_req & dbg_mode is ignored.
- DRAIN (01), ifu_halt_req=1:
  - Wake has priority -> WAKE. WFI completes as a NOP and core_wfi is never asserted.
  - Else ifu_halt_ack & pipe_idle in the same cycle -> SLEEP.
  - No timeout; DRAIN waits indefinitely.
- SLEEP (10), ifu_halt_req=1, core_wfi=1:
  - Wake -> WAKE; core_wfi drops on that edge.
  - ifu_halt_ack / pipe_idle changes are ignored.
- WAKE (11), ifu_halt_req=1, core_wfi=0:
  - Counter loads WAKE_DLY on entry and decrements each cycle.
  - At count 0 -> RUN: ifu_halt_req drops and wfi_wake=1 for that one cycle.
  - WAKE_DLY=0 gives exactly one WAKE cycle.
  - Wake deasserting during WAKE does not abort the sequence.
- Latency:
  - wfi_req at edge N -> ifu_halt_req=1 after edge N+1.
  - Drain complete at cycle M -> core_wfi=1 after edge M+1.
  - Wake at cycle K -> core_wfi=0 after edge K+1 -> RUN after WAKE_DLY+1 further edges.
- wfi_req is ignored outside RUN. A new wfi_req in the same cycle as wfi_wake is honoured (state is RUN).

Optional Feature:
- Macro: E203_WFI_SLEEP_CNT_EN.
- Enabled:
  - Adds output sleep_cycles [31:0]: saturating count of cycles spent in SLEEP, cleared by rst.
  - Adds input sleep_cnt_clr [0:0]: synchronous clear. Clear has priority over increment in the same cycle.
  - The count saturates at 32'hFFFF_FFFF and does not wrap.
- Disabled: neither port exists and no counter flops are generated; FSM behaviour is identical.

Decomposition:
- Shared package e203_wfi_pkg:
  - State encoding constants WFI_RUN=2'b00, WFI_DRAIN=2'b01, WFI_SLEEP=2'b10, WFI_WAKE=2'b11.
  - Default WAKE_DLY constant.
- Sub-module e203_wfi_dly_cnt: load/decrement/zero-detect counter. It is the only natural split; the FSM stays in the top.

Test Plan:
- Basic sleep/wake, WAKE_DLY=2:
  - Stimulus: wfi_req pulse; ack+idle 3 cycles later; wake_irq 10 cycles later.
  - Response: ifu_halt_req rises 1 cycle after wfi_req. core_wfi is high from 1 cycle after ack+idle until 1 cycle after wake_irq. wfi_wake pulses exactly 3 cycles after core_wfi falls. ifu_halt_req falls with wfi_wake.
- Interrupt pending at WFI:
  - Stimulus: wake_irq=1 held; wfi_req pulse.
  - Response: DRAIN->WAKE with core_wfi never 1; wfi_wake after WAKE_DLY+2 cycles.
- Debug mode:
  - Stimulus: dbg_mode=1; wfi_req pulse.
  - Response: state stays 00; no output toggles.
  - Stimulus: in SLEEP, dbg_irq=1 for one cycle.
  - Response: full wake sequence completes even after dbg_irq drops.
- Partial drain:
  - Stimulus: ifu_halt_ack=1 but pipe_idle=0 for 20 cycles, then pipe_idle=1.
  - Response: remains DRAIN 20 cycles; SLEEP entered on next edge.
- Reset mid-sleep:
  - Stimulus: rst=1 for one cycle while in SLEEP, then in WAKE with count 1.
  - Response: next cycle state 00, all outputs 0, no wfi_wake pulse.
- E203_WFI_SLEEP_CNT_EN:
  - Stimulus: 50 cycles in SLEEP.
  - Response: sleep_cycles=50.
  - Stimulus: preload near max via force to 32'hFFFF_FFFE; 5 more SLEEP cycles.
  - Response: holds 32'hFFFF_FFFF.
  - Stimulus: sleep_cnt_clr with SLEEP active.
  - Response: reads 0 next cycle.
